boton_eventos: RTL and testbench
================================

# boton_eventos

Press classifier sitting directly downstream of the button debouncer in the modes & buttons path. Takes one debounced, clock-synchronous button level and turns it into single-cycle event pulses: short press, long press and, optionally, auto-repeat while held. Also keeps a wrapping mode index that advances on every long press. This gives the mode/FSM logic clean, single-cycle events instead of raw levels.

## Interface
- LONG_COUNT, 5: consecutive high samples that qualify a long press (hardware build: 250000000 at 50 MHz); must be ≥ 2
- REPEAT_COUNT, 3: high samples between auto-repeat pulses after a long press; must be ≥ 1
- NUM_MODES, 4: number of modes; mode wraps at NUM_MODES-1; must be ≥ 2
- clk  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- boton_in  input  1  debounced button level from the debouncer, synchronous to clk (1 = pressed)
- short_pulse  output  1  one-cycle pulse on release of a short press
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_COUNT
- repeat_pulse  output  1  one-cycle pulse every REPEAT_COUNT held samples after long_pulse
- held  output  1  high while state is PRESSED or LONG
- mode  output  $clog2(NUM_MODES)  current mode index

## Operation
- States: WAIT_REL, IDLE, PRESSED, LONG. Reset state is WAIT_REL.
- Counter cnt width is $clog2(max(LONG_COUNT, REPEAT_COUNT)+1). Reset value is 0.
- All outputs are registered. On reset: short_pulse, long_pulse, repeat_pulse and held are 0; mode is 0.
- The pulse outputs default to 0 every cycle. They are set for exactly one cycle only by the transitions listed below.
- WAIT_REL: when boton_in is sampled 0, go to IDLE. No events are generated in WAIT_REL. This means a button already held across reset never yields an event.
- IDLE: when boton_in is sampled 1, go to PRESSED and load cnt ← 1.
- PRESSED, boton_in = 1:
  - if cnt == LONG_COUNT-1: set long_pulse, increment mode, load cnt ← 0, go to LONG;
  - otherwise cnt ← cnt+1.
- PRESSED, boton_in = 0: set short_pulse and go to IDLE.
- LONG, boton_in = 0: go to IDLE with no pulse.
- LONG, boton_in = 1: repeat behaviour is set by the Configuration section.
- Mode increment: if mode == NUM_MODES-1, mode ← 0; otherwise mode ← mode+1.
- In IDLE and WAIT_REL, cnt is 0.

## Timing
- Latency of one cycle from the deciding sample to the pulse:
  - short_pulse is high in the cycle after the first low sample;
  - long_pulse is high in the cycle after the LONG_COUNT-th consecutive high sample;
  - mode updates in the same cycle as long_pulse.
- Press of N consecutive high samples:
  - N < LONG_COUNT: exactly one short_pulse;
  - N ≥ LONG_COUNT: exactly one long_pulse and no short_pulse.
- held rises in the cycle after the first high sample. It falls in the cycle after the first low sample.
- A release followed immediately by a new press is legal. The IDLE→PRESSED transition costs one low sample.
- Reset mid-press takes effect immediately and asynchronously. Any pending pulse is lost, and mode returns to 0.

## Configuration
- Macro: BOTON_REPEAT_EN.
- Defined, in LONG with boton_in = 1:
  - if cnt == REPEAT_COUNT-1: set repeat_pulse and load cnt ← 0;
  - otherwise cnt ← cnt+1.
  - First repeat pulse follows held high sample LONG_COUNT+REPEAT_COUNT. Subsequent pulses follow every REPEAT_COUNT further samples.
- Undefined: LONG holds cnt at 0 and repeat_pulse is tied to 0. The port remains present.
- Repeat pulses never change mode.

## Test plan
Parameters for all scenarios: LONG_COUNT = 5, REPEAT_COUNT = 3, NUM_MODES = 4.
- Reset, boton_in = 0 → all outputs 0; IDLE after 1 cycle. Drive 3 high samples then 0 → short_pulse high one cycle after the first 0, mode = 0, held high for 3 cycles.
- 4 high samples → one short_pulse. 5 high samples → one long_pulse after the 5th sample and no short_pulse on release; mode = 1.
- Four separate 7-sample presses → mode sequence 1, 2, 3, 0; four long_pulses; zero short_pulses.
- With BOTON_REPEAT_EN: 14 consecutive high samples → long_pulse after sample 5, repeat_pulse after samples 8, 11 and 14, and nothing on release. Without the macro → only long_pulse.
- Assert reset asynchronously while held, with cnt = 3 → outputs 0 and mode 0 without waiting for a clock edge. Release reset with boton_in still 1 for 10 cycles → no pulses and held = 0. Then drive 0, then 2 high samples, then 0 → one short_pulse.
- Press ending at the same sample that would reach LONG_COUNT (4 high samples, then 0) → short_pulse only; long_pulse stays 0.

Source files
------------

// File: rtl/boton_eventos.sv
// boton_eventos: press classifier for a debounced, clk-synchronous button.
// Turns the button level into single-cycle short/long/repeat events and keeps
// a wrapping mode index that advances on every long press.
// Optional feature: define BOTON_REPEAT_EN to enable auto-repeat pulses while
// the button stays held after a long press. Without it repeat_pulse is tied 0.

module boton_eventos #(
  parameter int LONG_COUNT   = 5,
  parameter int REPEAT_COUNT = 3,
  parameter int NUM_MODES    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         boton_in,
  output logic                         short_pulse,
  output logic                         long_pulse,
  output logic                         repeat_pulse,
  output logic                         held,
  output logic [$clog2(NUM_MODES)-1:0] mode
);

  localparam int MODE_W  = $clog2(NUM_MODES);
  localparam int CNT_MAX = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);

  // WAIT_REL exists so a button already held when reset releases is ignored
  // until it has been seen released at least once.
  typedef enum logic [1:0] {
    S_WAIT_REL = 2'd0,
    S_IDLE     = 2'd1,
    S_PRESSED  = 2'd2,
    S_LONG     = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [MODE_W-1:0]  mode_q;
  logic [MODE_W-1:0]  mode_inc_d;
  logic               short_q;
  logic               long_q;
  logic               held_q;

`ifdef BOTON_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
  logic               repeat_q;
`endif

  // Wrapping successor of the current mode, used on every long press.
  always_comb begin
    mode_inc_d = mode_q + MODE_ONE;
    if (mode_q == MODE_LAST) begin
      mode_inc_d = '0;
    end
  end

  // Press classifier FSM; all outputs are registered here, pulses default low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT_REL;
      cnt_q    <= '0;
      mode_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
`ifdef BOTON_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
`ifdef BOTON_REPEAT_EN
      repeat_q <= 1'b0;
`endif
      case (state_q)
        S_WAIT_REL: begin
          cnt_q  <= '0;
          held_q <= 1'b0;
          if (!boton_in) begin
            state_q <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (boton_in) begin
            state_q <= S_PRESSED;
            cnt_q   <= CNT_ONE;
            held_q  <= 1'b1;
          end else begin
            cnt_q  <= '0;
            held_q <= 1'b0;
          end
        end

        S_PRESSED: begin
          if (boton_in) begin
            held_q <= 1'b1;
            // cnt_q holds the number of high samples seen so far, so the
            // sample arriving at LONG_COUNT-1 is the LONG_COUNT-th one.
            if (cnt_q == LONG_LAST) begin
              long_q  <= 1'b1;
              mode_q  <= mode_inc_d;
              cnt_q   <= '0;
              state_q <= S_LONG;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            short_q <= 1'b1;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end

        S_LONG: begin
          if (boton_in) begin
            held_q <= 1'b1;
`ifdef BOTON_REPEAT_EN
            if (cnt_q == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
`else
            cnt_q <= '0;
`endif
          end else begin
            held_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_WAIT_REL;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign held         = held_q;
  assign mode         = mode_q;
`ifdef BOTON_REPEAT_EN
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_boton_eventos.sv
// Testbench for boton_eventos: fixed vector table, directed multi-cycle
// sequences and random press patterns against a run-length reference model.

module tb_boton_eventos;

  localparam int LC = 5;
  localparam int RC = 3;
  localparam int NM = 4;
  localparam int MW = $clog2(NM);
`ifdef BOTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          boton_in = 1'b0;
  logic          short_pulse, long_pulse, repeat_pulse, held;
  logic [MW-1:0] mode;

  int n_chk = 0;
  int n_fail = 0;
  int n_short = 0, n_long = 0, n_rep = 0;

  // reference model state: armed after a low sample, length of current high run
  bit m_armed;
  int m_run;
  int m_mode;
  logic e_short, e_long, e_rep, e_held;

  typedef struct {
    logic          b;
    logic          s, l, r, h;
    logic [MW-1:0] m;
  } tv_t;

  tv_t tv[16];

  boton_eventos #(
    .LONG_COUNT(LC), .REPEAT_COUNT(RC), .NUM_MODES(NM)
  ) dut (
    .clk(clk), .reset(reset), .boton_in(boton_in),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .held(held), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_run = 0; m_mode = 0;
    e_short = 0; e_long = 0; e_rep = 0; e_held = 0;
  endtask

  task automatic model_step(input logic b);
    e_short = 0; e_long = 0; e_rep = 0;
    if (!m_armed) begin
      if (!b) m_armed = 1'b1;
      e_held = 0;
    end else if (b) begin
      m_run++;
      e_held = 1;
      if (m_run == LC) begin
        e_long = 1;
        m_mode = (m_mode + 1) % NM;
      end else if (REP_EN && m_run > LC && ((m_run - LC) % RC) == 0) begin
        e_rep = 1;
      end
    end else begin
      if (m_run > 0 && m_run < LC) e_short = 1;
      m_run = 0;
      e_held = 0;
    end
  endtask

  task automatic check_model();
    chk("short", short_pulse, e_short);
    chk("long", long_pulse, e_long);
    chk("repeat", repeat_pulse, e_rep);
    chk("held", held, e_held);
    chk("mode", mode, m_mode[MW-1:0]);
  endtask

  // called at a negedge (or time 0); returns at a negedge with reset low
  task automatic do_reset(input logic b);
    boton_in = b;
    reset = 1'b1;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // called at a negedge; applies one sample and checks after the edge
  task automatic step(input logic b);
    boton_in = b;
    @(posedge clk);
    model_step(b);
    #1;
    check_model();
    if (short_pulse === 1'b1) n_short++;
    if (long_pulse === 1'b1) n_long++;
    if (repeat_pulse === 1'b1) n_rep++;
    @(negedge clk);
  endtask

  task automatic clr_counts();
    n_short = 0; n_long = 0; n_rep = 0;
  endtask

  initial begin
    //        b     s     l     r     h     m
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
    tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};

    // table: reset, 3-sample short, 4-sample short, 5-sample long
    do_reset(1'b0);
    clr_counts();
    for (int i = 0; i < 16; i++) begin
      step(tv[i].b);
      chk("tbl_short", short_pulse, tv[i].s);
      chk("tbl_long", long_pulse, tv[i].l);
      chk("tbl_repeat", repeat_pulse, tv[i].r);
      chk("tbl_held", held, tv[i].h);
      chk("tbl_mode", mode, tv[i].m);
    end
    chk("tbl_n_short", n_short[7:0], 8'd2);
    chk("tbl_n_long", n_long[7:0], 8'd1);

    // four 7-sample presses: mode walks 1,2,3,0
    do_reset(1'b0);
    step(1'b0);
    clr_counts();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 7; k++) step(1'b1);
      step(1'b0);
      chk("wrap_mode", mode, 8'((p + 1) % NM));
    end
    chk("wrap_n_long", n_long[7:0], 8'd4);
    chk("wrap_n_short", n_short[7:0], 8'd0);

    // 14-sample hold: long after 5, repeats after 8, 11, 14 when enabled
    do_reset(1'b0);
    step(1'b0);
    clr_counts();
    for (int k = 0; k < 14; k++) step(1'b1);
    step(1'b0);
    chk("hold14_n_long", n_long[7:0], 8'd1);
    chk("hold14_n_rep", n_rep[7:0], REP_EN ? 8'd3 : 8'd0);
    chk("hold14_n_short", n_short[7:0], 8'd0);

    // asynchronous reset mid-press, mode previously 1
    do_reset(1'b0);
    step(1'b0);
    for (int k = 0; k < 5; k++) step(1'b1);
    step(1'b0);
    for (int k = 0; k < 3; k++) step(1'b1);
    chk("pre_rst_held", held, 8'd1);
    chk("pre_rst_mode", mode, 8'd1);
    do_reset(1'b1);
    clr_counts();
    for (int k = 0; k < 10; k++) step(1'b1);
    chk("held_thru_rst_n", n_short[7:0] + n_long[7:0] + n_rep[7:0], 8'd0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    chk("post_rst_n_short", n_short[7:0], 8'd1);

    // random press/release runs with occasional async resets
    do_reset(1'b0);
    begin
      logic lvl;
      lvl = 1'b0;
      for (int r = 0; r < 300; r++) begin
        int len;
        len = $urandom_range(1, 16);
        for (int k = 0; k < len; k++) step(lvl);
        if ($urandom_range(0, 39) == 0) do_reset(lvl);
        lvl = ~lvl;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
